// File: rtl/cache_ctrl.sv
// cache_ctrl: sequences CPU requests against a single-cycle registered cache
// stage and a handshaked backing memory. Reads look up the cache and fall back
// to memory on a miss (filling the cache); writes go to the cache and then
// through to memory; flush clears the cache and the hit/miss statistics.
//
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   cpu_req/op/tag/wdata    CPU request (accepted only while cpu_ready=1)
//   cpu_ready               high only while idle
//   cpu_valid/rdata/hit     one-cycle completion pulse with read data and hit flag
//   cache_vector            {opcode,tag,data} command to the cache stage
//   cache_enable            active-low cache strobe
//   cache_data, cache_hit   registered cache result (1-cycle latency)
//   mem_req/we/addr/wdata   backing-memory request
//   mem_rdata, mem_ack      backing-memory response
//   hit_count, miss_count   saturating read statistics
module cache_ctrl #(
    parameter int TAG_WIDTH    = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 2
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       cpu_req,
    input  logic [1:0]                                 cpu_op,
    input  logic [TAG_WIDTH-1:0]                       cpu_tag,
    input  logic [DATA_WIDTH-1:0]                      cpu_wdata,
    output logic                                       cpu_ready,
    output logic                                       cpu_valid,
    output logic [DATA_WIDTH-1:0]                      cpu_rdata,
    output logic                                       cpu_hit,
    output logic [OPCODE_WIDTH+TAG_WIDTH+DATA_WIDTH-1:0] cache_vector,
    output logic                                       cache_enable,
    input  logic [DATA_WIDTH-1:0]                      cache_data,
    input  logic                                       cache_hit,
    output logic                                       mem_req,
    output logic                                       mem_we,
    output logic [TAG_WIDTH-1:0]                       mem_addr,
    output logic [DATA_WIDTH-1:0]                      mem_wdata,
    input  logic [DATA_WIDTH-1:0]                      mem_rdata,
    input  logic                                       mem_ack,
    output logic [15:0]                                hit_count,
    output logic [15:0]                                miss_count
);

    localparam int LINE_WIDTH = OPCODE_WIDTH + TAG_WIDTH + DATA_WIDTH;

    localparam logic [1:0] CPU_FLUSH = 2'b00;
    localparam logic [1:0] CPU_READ  = 2'b01;
    localparam logic [1:0] CPU_WRITE = 2'b10;

    localparam logic [OPCODE_WIDTH-1:0] CACHE_FLUSH = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] CACHE_READ  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] CACHE_WRITE = OPCODE_WIDTH'(2);

    typedef enum logic [3:0] {
        IDLE, LOOKUP, CHECK, MEM_RD, FILL, WR_CACHE, WR_MEM, FLUSH, RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [DATA_WIDTH-1:0]  fill_q;

    // Statistics stick at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Next state and all command outputs decode from the current state, so an
    // asynchronous reset silences the cache and memory ports immediately.
    always_comb begin
        state_d      = state_q;
        cpu_ready    = 1'b0;
        cpu_valid    = 1'b0;
        cache_enable = 1'b1;
        cache_vector = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (state_q)
            IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req) begin
                    case (cpu_op)
                        CPU_READ:  state_d = LOOKUP;
                        CPU_WRITE: state_d = WR_CACHE;
                        CPU_FLUSH: state_d = FLUSH;
                        default:   state_d = RESP;
                    endcase
                end
            end
            LOOKUP: begin
                cache_enable = 1'b0;
                cache_vector = {CACHE_READ, tag_q, {DATA_WIDTH{1'b0}}};
                state_d      = CHECK;
            end
            CHECK: state_d = cache_hit ? RESP : MEM_RD;
            MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = tag_q;
                if (mem_ack) state_d = FILL;
            end
            FILL: begin
                cache_enable = 1'b0;
                cache_vector = {CACHE_WRITE, tag_q, fill_q};
                state_d      = RESP;
            end
            WR_CACHE: begin
                cache_enable = 1'b0;
                cache_vector = {CACHE_WRITE, tag_q, wdata_q};
                state_d      = WR_MEM;
            end
            WR_MEM: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = tag_q;
                mem_wdata = wdata_q;
                if (mem_ack) state_d = RESP;
            end
            FLUSH: begin
                cache_enable = 1'b0;
                cache_vector = {CACHE_FLUSH, {TAG_WIDTH{1'b0}}, {DATA_WIDTH{1'b0}}};
                state_d      = RESP;
            end
            RESP: begin
                cpu_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tag_q      <= '0;
            wdata_q    <= '0;
            fill_q     <= '0;
            cpu_rdata  <= '0;
            cpu_hit    <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        tag_q     <= cpu_tag;
                        wdata_q   <= cpu_wdata;
                        // Everything except a read hit or fill reports zero data, no hit.
                        cpu_rdata <= '0;
                        cpu_hit   <= 1'b0;
                    end
                end
                CHECK: begin
                    if (cache_hit) begin
                        cpu_rdata <= cache_data;
                        cpu_hit   <= 1'b1;
                        hit_count <= sat_inc(hit_count);
                    end else begin
                        miss_count <= sat_inc(miss_count);
                    end
                end
                MEM_RD: if (mem_ack) fill_q <= mem_rdata;
                FILL: begin
                    cpu_rdata <= fill_q;
                    cpu_hit   <= 1'b0;
                end
                FLUSH: begin
                    hit_count  <= '0;
                    miss_count <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
